// File: rtl/pwm_speed_ramp_ctrl_if.sv
// Command port of the PWM speed ramp controller.
// The master presents cmd_valid/cmd_code; the controller answers with cmd_ready/cmd_err.
interface pwm_speed_ramp_ctrl_if;
  // Handshake: a command transfers on every rising clk edge where cmd_valid and
  // cmd_ready are both 1. cmd_code must be stable while cmd_valid is high.
  // cmd_err is a one-cycle pulse that follows a rejected transfer.
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic       cmd_err;

  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready,
    output cmd_err
  );
endinterface

// File: rtl/pwm_speed_ramp_ctrl.sv
// Speed controller for a PWM generator: turns speed commands into a duty ramp
// that only moves high_dur on PWM period boundaries. ESTOP forces 0% and latches FAULT.
module pwm_speed_ramp_ctrl #(
  parameter int PERIOD       = 50000,
  parameter int STEP         = 500,
  parameter int RAMP_PERIODS = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pwm_speed_ramp_ctrl_if.slave    cmd,
  output logic [31:0]             total_dur,
  output logic [31:0]             high_dur,
  output logic [1:0]              state,
  output logic                    at_speed
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_STEADY = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  localparam logic [31:0] PERIOD_M1 = 32'(PERIOD - 1);
  localparam logic [31:0] RD_LAST   = 32'(RAMP_PERIODS - 1);
  localparam logic [31:0] STEP_W    = 32'(STEP);
  localparam logic [31:0] LVL_1     = 32'(PERIOD / 4);
  localparam logic [31:0] LVL_2     = 32'((PERIOD / 4) * 2);
  localparam logic [31:0] LVL_3     = 32'((PERIOD / 4) * 3);
  localparam logic [31:0] LVL_4     = 32'(PERIOD);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] high_q, high_d;
  logic [31:0] target_q, target_d;
  logic        err_q, err_d;
  state_e      state_q, state_d;

  logic        boundary;
  logic        ramp_ev;
  logic        accept;
  logic        estop;
  logic [31:0] level_target;
  logic [31:0] stepped;
  logic [32:0] up_sum;
  logic [32:0] dn_diff;

  assign cmd.cmd_ready = reset_n;
  assign cmd.cmd_err   = err_q;
  assign total_dur     = PERIOD_M1;
  assign high_dur      = high_q;
  assign state         = state_q;
  assign at_speed      = (high_q == target_q) && (state_q != ST_FAULT);

  assign boundary = (pc_q == PERIOD_M1);
  assign ramp_ev  = boundary && (rd_q == RD_LAST);
  assign accept   = cmd.cmd_valid;
  assign estop    = accept && (cmd.cmd_code == 3'd7);

  // Period counter and ramp divider free-run so they stay aligned with the generator tick.
  always_comb begin
    pc_d = boundary ? 32'd0 : pc_q + 32'd1;
    rd_d = rd_q;
    if (boundary) begin
      rd_d = (rd_q == RD_LAST) ? 32'd0 : rd_q + 32'd1;
    end
  end

  always_comb begin
    level_target = 32'd0;
    case (cmd.cmd_code)
      3'd1:    level_target = LVL_1;
      3'd2:    level_target = LVL_2;
      3'd3:    level_target = LVL_3;
      3'd4:    level_target = LVL_4;
      default: level_target = 32'd0;
    endcase
  end

  // One ramp step toward the current target, clamped so it never overshoots or underflows.
  always_comb begin
    up_sum  = {1'b0, high_q} + {1'b0, STEP_W};
    dn_diff = {1'b0, high_q} - {1'b0, target_q};
    stepped = high_q;
    if (high_q < target_q) begin
      stepped = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[31:0];
    end else if (high_q > target_q) begin
      stepped = (dn_diff < {1'b0, STEP_W}) ? target_q : high_q - STEP_W;
    end
  end

  always_comb begin
    high_d   = high_q;
    target_d = target_q;
    err_d    = 1'b0;
    state_d  = state_q;

    // The step above uses the old target, so a command in the same cycle waits for the next event.
    if (ramp_ev && (state_q != ST_FAULT)) begin
      high_d = stepped;
    end

    if (accept) begin
      case (cmd.cmd_code)
        3'd0: target_d = 32'd0;
        3'd1, 3'd2, 3'd3, 3'd4: begin
          if (state_q == ST_FAULT) err_d = 1'b1;
          else                     target_d = level_target;
        end
        3'd7:    target_d = 32'd0;
        default: err_d = 1'b1;
      endcase
    end

    if (estop) begin
      high_d   = 32'd0;
      target_d = 32'd0;
      state_d  = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      state_d = (accept && (cmd.cmd_code == 3'd0)) ? ST_IDLE : ST_FAULT;
    end else if ((target_d == 32'd0) && (high_d == 32'd0)) begin
      state_d = ST_IDLE;
    end else if (high_d == target_d) begin
      state_d = ST_STEADY;
    end else begin
      state_d = ST_RAMP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= 32'd0;
      rd_q     <= 32'd0;
      high_q   <= 32'd0;
      target_q <= 32'd0;
      err_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      high_q   <= high_d;
      target_q <= target_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_pwm_speed_ramp_ctrl.sv
// Directed bench for pwm_speed_ramp_ctrl: PERIOD=100, STEP=10 with RAMP_PERIODS=1 (dut_a)
// and RAMP_PERIODS=3 (dut_b). Edge numbers count rising edges since that DUT left reset.
module tb_pwm_speed_ramp_ctrl;

  logic        clk;
  logic        rst_a_n, rst_b_n;
  logic [31:0] total_a, high_a, total_b, high_b;
  logic [1:0]  state_a, state_b;
  logic        at_a, at_b;

  int n_cmp;
  int n_bad;
  int cyc;

  pwm_speed_ramp_ctrl_if if_a ();
  pwm_speed_ramp_ctrl_if if_b ();

  pwm_speed_ramp_ctrl #(.PERIOD(100), .STEP(10), .RAMP_PERIODS(1)) dut_a (
    .clk       (clk),
    .reset_n   (rst_a_n),
    .cmd       (if_a),
    .total_dur (total_a),
    .high_dur  (high_a),
    .state     (state_a),
    .at_speed  (at_a)
  );

  pwm_speed_ramp_ctrl #(.PERIOD(100), .STEP(10), .RAMP_PERIODS(3)) dut_b (
    .clk       (clk),
    .reset_n   (rst_b_n),
    .cmd       (if_b),
    .total_dur (total_b),
    .high_dur  (high_b),
    .state     (state_b),
    .at_speed  (at_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          edge_n;
    logic        cmd_v;
    logic [2:0]  code;
    logic [31:0] exp_high;
    logic [1:0]  exp_state;
    logic        exp_at;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add(input int e, input logic v, input logic [2:0] c, input logic [31:0] h,
                     input logic [1:0] s, input logic a, input logic r);
    vec_t t;
    t.edge_n = e; t.cmd_v = v; t.code = c;
    t.exp_high = h; t.exp_state = s; t.exp_at = a; t.exp_err = r;
    vecs.push_back(t);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    if_a.cmd_valid = 1'b0; if_a.cmd_code = 3'd0;
    if_b.cmd_valid = 1'b0; if_b.cmd_code = 3'd0;

    // edge, valid, code, high, state, at_speed, cmd_err
    add(5,    1, 3'd2,  0, 2'd1, 0, 0);
    add(99,   0, 3'd0,  0, 2'd1, 0, 0);
    add(100,  0, 3'd0, 10, 2'd1, 0, 0);
    add(199,  0, 3'd0, 10, 2'd1, 0, 0);
    add(200,  0, 3'd0, 20, 2'd1, 0, 0);
    add(300,  0, 3'd0, 30, 2'd1, 0, 0);
    add(400,  0, 3'd0, 40, 2'd1, 0, 0);
    add(500,  0, 3'd0, 50, 2'd2, 1, 0);
    add(550,  1, 3'd1, 50, 2'd1, 0, 0);
    add(600,  0, 3'd0, 40, 2'd1, 0, 0);
    add(700,  0, 3'd0, 30, 2'd1, 0, 0);
    add(799,  0, 3'd0, 30, 2'd1, 0, 0);
    add(800,  0, 3'd0, 25, 2'd2, 1, 0);
    add(850,  1, 3'd0, 25, 2'd1, 0, 0);
    add(900,  0, 3'd0, 15, 2'd1, 0, 0);
    add(1000, 0, 3'd0,  5, 2'd1, 0, 0);
    add(1100, 0, 3'd0,  0, 2'd0, 1, 0);
    add(1150, 1, 3'd3,  0, 2'd1, 0, 0);
    add(1200, 0, 3'd0, 10, 2'd1, 0, 0);
    add(1300, 0, 3'd0, 20, 2'd1, 0, 0);
    add(1400, 0, 3'd0, 30, 2'd1, 0, 0);
    add(1450, 1, 3'd7,  0, 2'd3, 0, 0);
    add(1500, 0, 3'd0,  0, 2'd3, 0, 0);
    add(1550, 1, 3'd3,  0, 2'd3, 0, 1);
    add(1551, 0, 3'd0,  0, 2'd3, 0, 0);
    add(1600, 1, 3'd0,  0, 2'd0, 1, 0);
    add(1700, 0, 3'd0,  0, 2'd0, 1, 0);
    add(1750, 1, 3'd4,  0, 2'd1, 0, 0);
    add(1800, 0, 3'd0, 10, 2'd1, 0, 0);
    add(1900, 0, 3'd0, 20, 2'd1, 0, 0);
    add(2000, 0, 3'd0, 30, 2'd1, 0, 0);
    add(2100, 0, 3'd0, 40, 2'd1, 0, 0);
    add(2199, 0, 3'd0, 40, 2'd1, 0, 0);
    add(2200, 1, 3'd1, 50, 2'd1, 0, 0);
    add(2300, 0, 3'd0, 40, 2'd1, 0, 0);
    add(2400, 0, 3'd0, 30, 2'd1, 0, 0);
    add(2500, 0, 3'd0, 25, 2'd2, 1, 0);
    add(2550, 1, 3'd5, 25, 2'd2, 1, 1);
    add(2551, 0, 3'd0, 25, 2'd2, 1, 0);
    add(2552, 1, 3'd6, 25, 2'd2, 1, 1);
    add(2560, 1, 3'd2, 25, 2'd1, 0, 0);
    add(2600, 1, 3'd7,  0, 2'd3, 0, 0);
    add(2700, 0, 3'd0,  0, 2'd3, 0, 0);
    add(2750, 1, 3'd0,  0, 2'd0, 1, 0);

    // Reset values while reset is held.
    #2;
    chk("rst.high",  high_a,  32'd0);
    chk("rst.total", total_a, 32'd99);
    chk("rst.state", {30'd0, state_a}, 32'd0);
    chk("rst.at",    {31'd0, at_a}, 32'd1);
    chk("rst.err",   {31'd0, if_a.cmd_err}, 32'd0);
    #10;
    rst_a_n = 1'b1;
    #1;
    chk("rst.ready", {31'd0, if_a.cmd_ready}, 32'd1);

    foreach (vecs[i]) begin
      while (cyc < vecs[i].edge_n - 1) step();
      if (vecs[i].cmd_v) begin
        if_a.cmd_valid = 1'b1;
        if_a.cmd_code  = vecs[i].code;
      end
      step();
      if_a.cmd_valid = 1'b0;
      if_a.cmd_code  = 3'd0;
      chk($sformatf("v%0d@%0d.high", i, vecs[i].edge_n), high_a, vecs[i].exp_high);
      chk($sformatf("v%0d@%0d.state", i, vecs[i].edge_n), {30'd0, state_a}, {30'd0, vecs[i].exp_state});
      chk($sformatf("v%0d@%0d.at", i, vecs[i].edge_n), {31'd0, at_a}, {31'd0, vecs[i].exp_at});
      chk($sformatf("v%0d@%0d.err", i, vecs[i].edge_n), {31'd0, if_a.cmd_err}, {31'd0, vecs[i].exp_err});
    end
    chk("a.total", total_a, 32'd99);
    chk("a.ready", {31'd0, if_a.cmd_ready}, 32'd1);

    // dut_b: three PWM periods between ramp events, then reset mid-ramp.
    rst_b_n = 1'b1;
    cyc = 0;
    while (cyc < 4) step();
    if_b.cmd_valid = 1'b1; if_b.cmd_code = 3'd4;
    step();
    if_b.cmd_valid = 1'b0; if_b.cmd_code = 3'd0;
    chk("b.cmd4.state", {30'd0, state_b}, 32'd1);
    while (cyc < 200) step();
    chk("b.e200.high", high_b, 32'd0);
    while (cyc < 299) step();
    chk("b.e299.high", high_b, 32'd0);
    step();
    chk("b.e300.high", high_b, 32'd10);
    while (cyc < 599) step();
    chk("b.e599.high", high_b, 32'd10);
    step();
    chk("b.e600.high", high_b, 32'd20);
    while (cyc < 650) step();
    #2;
    rst_b_n = 1'b0;
    #1;
    chk("b.rst.high",  high_b, 32'd0);
    chk("b.rst.state", {30'd0, state_b}, 32'd0);
    chk("b.rst.at",    {31'd0, at_b}, 32'd1);
    chk("b.rst.total", total_b, 32'd99);
    chk("b.rst.err",   {31'd0, if_b.cmd_err}, 32'd0);
    step();
    step();
    rst_b_n = 1'b1;
    cyc = 0;
    // Counters must restart from zero: the first ramp event is again 300 edges out.
    while (cyc < 4) step();
    if_b.cmd_valid = 1'b1; if_b.cmd_code = 3'd1;
    step();
    if_b.cmd_valid = 1'b0; if_b.cmd_code = 3'd0;
    chk("b2.cmd1.state", {30'd0, state_b}, 32'd1);
    while (cyc < 299) step();
    chk("b2.e299.high", high_b, 32'd0);
    step();
    chk("b2.e300.high", high_b, 32'd10);
    while (cyc < 600) step();
    chk("b2.e600.high", high_b, 32'd20);
    chk("b2.e600.state", {30'd0, state_b}, 32'd1);
    while (cyc < 900) step();
    chk("b2.e900.high", high_b, 32'd25);
    chk("b2.e900.state", {30'd0, state_b}, 32'd2);
    chk("b2.e900.at", {31'd0, at_b}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
